// File: rtl/flopskid_pkg.sv
// Shared types and constants for the flopskid two-entry skid buffer.
package flopskid_pkg;

  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_t;

  localparam int STALLCNT_W = 32;

endpackage

// File: rtl/flopenar.sv
// Enable register with asynchronous active-low reset to zero.
module flopenar #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/flopskid.sv
// Two-entry ready/valid skid buffer (main + skid register) with synchronous flush.
// Optional producer-stall counter enabled by defining FLOPSKID_STALLCNT_EN.
module flopskid
  import flopskid_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
`ifdef FLOPSKID_STALLCNT_EN
  output logic [STALLCNT_W-1:0] stall_cnt,
`endif
  output skid_state_t           dbg_state
);

  // Handshake: a beat moves when valid & ready are both high at a posedge;
  // valid never waits on ready, and in_ready depends only on state and flush.
  skid_state_t      state_q, state_d;
  logic             in_fire, out_fire;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_ready  = (state_q != SKID_FULL) & ~flush;
  assign out_valid = (state_q != SKID_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SKID_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (in_fire) begin
            main_en = 1'b1;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            skid_en = 1'b1;
            state_d = SKID_FULL;
          end else if (out_fire) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so only the drain path can move data.
          if (out_fire) begin
            main_en = 1'b1;
            main_d  = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  flopenar #(.WIDTH(WIDTH)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (main_en),
    .d       (main_d),
    .q       (main_q)
  );

  flopenar #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (skid_en),
    .d       (in_data),
    .q       (skid_q)
  );

`ifdef FLOPSKID_STALLCNT_EN
  logic [STALLCNT_W-1:0] stall_q;

  // Saturating count of cycles the producer is held off, flush cycles included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if (in_valid && !in_ready && (stall_q != {STALLCNT_W{1'b1}}))
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/flopskid.md
# flopskid

Two-entry ready/valid skid buffer that pipelines the consumer side of a stage boundary. It replaces a bare enable/clear pipeline register wherever the downstream stall arrives late in the cycle. A registered main entry plus a skid entry absorb one beat after the consumer drops `out_ready`. This gives full throughput, one-cycle latency, and a `ready` that never depends combinationally on `out_ready`. A synchronous `flush` discards all held beats, as the pipeline does on a branch mispredict or trap.

## Interface
- `WIDTH`, 64, payload width in bits.
- `clk`  in  1  clock; all state updates on posedge.
- `reset_n`  in  1  reset, asynchronous and active-low; clears all state immediately.
- `flush`  in  1  synchronous clear; discards held beats at the next edge.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  buffer accepts a beat this cycle.
- `in_data`  in  WIDTH  producer payload.
- `out_valid`  out  1  buffer presents `out_data`.
- `out_ready`  in  1  consumer takes a beat this cycle.
- `out_data`  out  WIDTH  consumer payload; always driven from the main register.
- `stall_cnt`  out  32  producer-stall counter; present only with `FLOPSKID_STALLCNT_EN`.

## Operation
- Definitions:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
- State is one of EMPTY, ONE or FULL, held in a register.
- `out_valid = (state != EMPTY)`.
- `in_ready = (state != FULL) & ~flush`. The only combinational input to `in_ready` is `flush`; it never depends on `out_ready`.
- Transitions, when `flush` = 0:
  - EMPTY: `in_fire` loads main and goes to ONE. Otherwise stay in EMPTY.
  - ONE, `in_fire & out_fire`: main <= `in_data`, stay in ONE.
  - ONE, `in_fire & ~out_fire`: skid <= `in_data`, go to FULL.
  - ONE, `~in_fire & out_fire`: go to EMPTY.
  - ONE, neither: hold.
  - FULL, `out_fire`: main <= skid, go to ONE. `in_fire` is impossible in FULL.
  - FULL, no `out_fire`: hold.
- Flush, which has priority over every transition:
  - Next state is EMPTY.
  - A beat with `out_fire` in the flush cycle counts as delivered.
  - Other held beats are dropped.
  - No input is accepted in the flush cycle.
- Ordering is strict FIFO: no beat is reordered, duplicated or lost except by flush.
- Data registers clear to 0 on reset only. They are not cleared on flush; when `out_valid` is 0, `out_data` content is don't-care.

## Timing
- Reset values: state EMPTY, main = 0, skid = 0, `out_valid` = 0, `stall_cnt` = 0.
- `in_ready` = 1 once `reset_n` is high and `flush` is low.
- Reset mid-operation: all beats are lost immediately, asynchronously.
- Latency: a beat accepted at edge N is visible on `out_data` with `out_valid` = 1 after edge N.
- Throughput: one beat per cycle while `out_ready` stays high.
- Backpressure: `out_ready` falling at edge N causes `in_ready` to fall after edge N+1 at the latest. At most one beat is absorbed into skid.
- `out_ready` rising in FULL:
  - The skid beat is presented after the next edge.
  - `in_ready` rises in that same cycle.
- A producer may hold `in_valid` with changing data while `in_ready` = 0; that data is not sampled.

## Configuration
- Macro: `FLOPSKID_STALLCNT_EN`.
- Defined:
  - `stall_cnt` port is present.
  - It increments by 1 each cycle with `in_valid & ~in_ready`, including flush cycles.
  - It saturates at 0xFFFF_FFFF and does not wrap.
  - It clears only on reset.
- Undefined:
  - Port and counter are absent.
  - Handshake behaviour is identical.

## Structure
- Package `flopskid_pkg`:
  - `typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_t`.
  - `localparam STALLCNT_W = 32`.
- Sub-module `flopenar #(WIDTH)`: enable register with asynchronous active-low reset. Instantiated twice, for main and skid.
- State logic and the counter stay in `flopskid`.

## Test plan
- Reset: `reset_n` = 0 mid-stream with FULL, holding 0xA and 0xB -> `out_valid` = 0 immediately. After release, `in_ready` = 1 and `out_data` = 0.
- Streaming: `out_ready` = 1 and beats 1..100 one per cycle -> each beat appears one cycle later, in order, with no bubbles.
- Backpressure: send 0x11, 0x22, 0x33 and drop `out_ready` after 0x11 is presented:
  - Buffer holds 0x11 and 0x22, `in_ready` = 0, and 0x33 waits.
  - Re-raising `out_ready` yields 0x11, 0x22, 0x33 in order.
- Flush in FULL with `out_ready` = 1:
  - 0x11 is delivered that cycle.
  - Next cycle `out_valid` = 0, the skid beat 0x22 is dropped, and `in_valid` is not sampled in the flush cycle.
- Flush in ONE with a simultaneous `in_valid` of 0x55 -> 0x55 is not accepted and the state is EMPTY next cycle.
- With `FLOPSKID_STALLCNT_EN`: hold `in_valid` = 1 for 7 cycles with FULL -> `stall_cnt` = 7. A forced value of 0xFFFF_FFFF remains 0xFFFF_FFFF on a further stall cycle.
